// File: rtl/display_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : display_pkg                                                   |
// | Brief    : Shared constants, slot type and select-code helper for the    |
// |            3-digit display scan controller.                              |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package display_pkg;

    localparam int BCD_W = 4;

    // Select codes are written as {SEL1, SEL0}.
    localparam logic [1:0] SLOT0_SEL = 2'b00;
    localparam logic [1:0] SLOT1_SEL = 2'b10;
    localparam logic [1:0] SLOT2_SEL = 2'b01;
    localparam logic [1:0] SEL_OFF   = 2'b11;

    typedef enum logic [1:0] {
        SLOT_0 = 2'd0,
        SLOT_1 = 2'd1,
        SLOT_2 = 2'd2
    } slot_t;

    function automatic logic [1:0] slot_sel(input slot_t s);
        case (s)
            SLOT_0:  return SLOT0_SEL;
            SLOT_1:  return SLOT1_SEL;
            SLOT_2:  return SLOT2_SEL;
            default: return SEL_OFF;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/display_prescaler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : display_prescaler                                             |
// | Brief    : Refresh prescaler; TICK marks the last cycle of a digit slot. |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module display_prescaler
    import display_pkg::*;
#(
    parameter int DIV   = 4,
    parameter int CNT_W = 16
) (
    input  logic CLK,
    input  logic RSTN,
    input  logic EN,
    output logic TICK
);

    localparam logic [CNT_W-1:0] c_last = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap = (r_cnt == c_last);

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_cnt <= '0;
        end else if (EN) begin
            r_cnt <= w_wrap ? '0 : r_cnt + c_one;
        end
    end

    // Gated by reset so no slot advance is ever signalled while reset is held.
    assign TICK = RSTN && EN && w_wrap;

endmodule
`default_nettype wire

// File: rtl/display_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : display_scanner                                               |
// | Brief    : Time-multiplexed scan controller for a 3-digit 7-segment      |
// |            display with double-buffered BCD digits. Optional leading-    |
// |            zero blanking is enabled by defining DISPLAY_BLANK_EN.        |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module display_scanner
    import display_pkg::*;
#(
    parameter int DIV   = 4,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             EN,
    input  logic             LOAD,
    input  logic [BCD_W-1:0] D0,
    input  logic [BCD_W-1:0] D1,
    input  logic [BCD_W-1:0] D2,
    output logic             SEL0,
    output logic             SEL1,
    output logic [BCD_W-1:0] DIGIT,
    output logic             TICK
);

    logic                  w_tick;
    slot_t                 r_slot;
    slot_t                 w_slot_next;
    logic [2:0][BCD_W-1:0] w_live;
    logic [2:0][BCD_W-1:0] r_shadow;
    logic [2:0][BCD_W-1:0] r_active;
    logic [2:0][BCD_W-1:0] w_active_next;
    logic                  r_pending;
    logic                  w_pending_next;
    logic [1:0]            r_sel;
    logic [1:0]            w_sel_next;
    logic [BCD_W-1:0]      r_digit;
    logic [BCD_W-1:0]      w_digit_next;

    display_prescaler #(
        .DIV   (DIV),
        .CNT_W (CNT_W)
    ) u_prescaler (
        .CLK  (CLK),
        .RSTN (RSTN),
        .EN   (EN),
        .TICK (w_tick)
    );

    assign w_live = {D2, D1, D0};

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_slot    <= SLOT_0;
            r_shadow  <= '0;
            r_active  <= '0;
            r_pending <= 1'b0;
            r_sel     <= SLOT0_SEL;
            r_digit   <= '0;
        end else begin
            r_slot    <= w_slot_next;
            r_active  <= w_active_next;
            r_pending <= w_pending_next;
            r_sel     <= w_sel_next;
            r_digit   <= w_digit_next;
            if (LOAD) begin
                r_shadow <= w_live;
            end
        end
    end

    // Everything that is displayed changes only on a slot boundary; the
    // registered outputs are computed from the post-tick slot and buffer.
    always_comb begin
        w_slot_next    = r_slot;
        w_active_next  = r_active;
        w_pending_next = r_pending;
        w_sel_next     = r_sel;
        w_digit_next   = r_digit;

        if (LOAD) begin
            w_pending_next = 1'b1;
        end

        if (w_tick) begin
            case (r_slot)
                SLOT_0:  w_slot_next = SLOT_1;
                SLOT_1:  w_slot_next = SLOT_2;
                default: w_slot_next = SLOT_0;
            endcase

            // A load landing on the boundary bypasses the shadow entirely.
            if (LOAD) begin
                w_active_next = w_live;
            end else if (r_pending) begin
                w_active_next = r_shadow;
            end
            w_pending_next = 1'b0;

            case (w_slot_next)
                SLOT_1:  w_digit_next = w_active_next[1];
                SLOT_2:  w_digit_next = w_active_next[2];
                default: w_digit_next = w_active_next[0];
            endcase

            w_sel_next = slot_sel(w_slot_next);
`ifdef DISPLAY_BLANK_EN
            if ((w_slot_next == SLOT_2) && (w_active_next[2] == '0)) begin
                w_sel_next = SEL_OFF;
            end
            if ((w_slot_next == SLOT_1) && (w_active_next[2] == '0) &&
                (w_active_next[1] == '0)) begin
                w_sel_next = SEL_OFF;
            end
`endif
        end
    end

    assign SEL1  = r_sel[1];
    assign SEL0  = r_sel[0];
    assign DIGIT = r_digit;
    assign TICK  = w_tick;

endmodule
`default_nettype wire

// File: tb/tb_display_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_display_scanner                                            |
// | Brief    : Self-checking bench for display_scanner (DIV=4); honours      |
// |            DISPLAY_BLANK_EN when defined.                                |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_display_scanner;

    localparam int DIV = 4;
`ifdef DISPLAY_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RSTN, EN, LOAD;
    logic [3:0] D0, D1, D2;
    logic       SEL0, SEL1, TICK;
    logic [3:0] DIGIT;

    always #5 CLK = ~CLK;

    display_scanner #(.DIV(DIV), .CNT_W(16)) dut (
        .CLK   (CLK),
        .RSTN  (RSTN),
        .EN    (EN),
        .LOAD  (LOAD),
        .D0    (D0),
        .D1    (D1),
        .D2    (D2),
        .SEL0  (SEL0),
        .SEL1  (SEL1),
        .DIGIT (DIGIT),
        .TICK  (TICK)
    );

    typedef struct packed {
        logic [1:0] sel;
        logic [3:0] digit;
        logic       tick;
    } exp_t;

    typedef struct packed {
        logic       en;
        logic       load;
        logic [3:0] d0, d1, d2;
        logic [1:0] sel;
        logic [3:0] dig;
        logic       tick;
    } vec_t;

    exp_t sbq[$];
    vec_t tbl[20];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model state
    int         m_cnt, m_slot;
    logic [3:0] m_act[3];
    logic [3:0] m_shd[3];
    bit         m_pend;
    logic [1:0] m_sel;
    logic [3:0] m_dig;

    function automatic vec_t v(input logic en, load, input logic [3:0] d0, d1, d2,
                               input logic [1:0] sel, input logic [3:0] dig, input logic tick);
        vec_t r;
        r = '{en, load, d0, d1, d2, sel, dig, tick};
        return r;
    endfunction

    function automatic logic [1:0] m_code(input int s, input logic [3:0] a1, input logic [3:0] a2);
        logic [1:0] c;
        c = (s == 0) ? 2'b00 : (s == 1) ? 2'b10 : 2'b01;
        if (BLANK && s == 2 && a2 == 4'd0) c = 2'b11;
        if (BLANK && s == 1 && a2 == 4'd0 && a1 == 4'd0) c = 2'b11;
        return c;
    endfunction

    task automatic m_reset();
        m_cnt = 0; m_slot = 0; m_pend = 1'b0; m_sel = 2'b00; m_dig = 4'd0;
        for (int i = 0; i < 3; i++) begin
            m_act[i] = 4'd0;
            m_shd[i] = 4'd0;
        end
    endtask

    task automatic m_step(input logic rstn, en, load, input logic [3:0] d0, d1, d2);
        bit t;
        if (!rstn) begin
            m_reset();
        end else begin
            t = en && (m_cnt == DIV - 1);
            if (en) m_cnt = (m_cnt + 1) % DIV;
            if (t) begin
                m_slot = (m_slot + 1) % 3;
                if (load) begin
                    m_act[0] = d0; m_act[1] = d1; m_act[2] = d2;
                end else if (m_pend) begin
                    m_act[0] = m_shd[0]; m_act[1] = m_shd[1]; m_act[2] = m_shd[2];
                end
                m_sel = m_code(m_slot, m_act[1], m_act[2]);
                m_dig = m_act[m_slot];
            end
            if (load) begin
                m_shd[0] = d0; m_shd[1] = d1; m_shd[2] = d2;
            end
            if (t) m_pend = 1'b0;
            else if (load) m_pend = 1'b1;
        end
    endtask

    // One clock cycle: drive, queue expectation, compare at negedge, advance model.
    task automatic drive(input string name, input logic rstn, en, load,
                         input logic [3:0] d0, d1, d2, input bit ovr, input exp_t eo);
        exp_t e, got;
        RSTN = rstn; EN = en; LOAD = load; D0 = d0; D1 = d1; D2 = d2;
        if (ovr) sbq.push_back(eo);
        else sbq.push_back('{m_sel, m_dig, rstn && en && (m_cnt == DIV - 1)});
        @(negedge CLK);
        e   = sbq.pop_front();
        got = '{{SEL1, SEL0}, DIGIT, TICK};
        n_vec++;
        if (got !== e) begin
            n_err++;
            $display("FAIL %s @%0t: got sel=%b digit=%0d tick=%b, want sel=%b digit=%0d tick=%b",
                     name, $time, got.sel, got.digit, got.tick, e.sel, e.digit, e.tick);
        end
        m_step(rstn, en, load, d0, d1, d2);
        @(posedge CLK);
        #1;
    endtask

    task automatic run(input string name, input int n, input logic en, load,
                       input logic [3:0] d0, d1, d2);
        for (int i = 0; i < n; i++) drive(name, 1'b1, en, load, d0, d1, d2, 1'b0, '0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int guard;

        // Per-cycle expectations after reset release, DIV=4, LOAD 3/7/9 mid-slot1.
        tbl[0]  = v(1, 0, 0, 0, 0, 2'b00, 0, 0);
        tbl[1]  = v(1, 0, 0, 0, 0, 2'b00, 0, 0);
        tbl[2]  = v(1, 0, 0, 0, 0, 2'b00, 0, 0);
        tbl[3]  = v(1, 0, 0, 0, 0, 2'b00, 0, 1);
        tbl[4]  = v(1, 0, 0, 0, 0, 2'b10, 0, 0);
        tbl[5]  = v(1, 1, 3, 7, 9, 2'b10, 0, 0);
        tbl[6]  = v(1, 0, 0, 0, 0, 2'b10, 0, 0);
        tbl[7]  = v(1, 0, 0, 0, 0, 2'b10, 0, 1);
        tbl[8]  = v(1, 0, 0, 0, 0, 2'b01, 9, 0);
        tbl[9]  = v(1, 0, 0, 0, 0, 2'b01, 9, 0);
        tbl[10] = v(1, 0, 0, 0, 0, 2'b01, 9, 0);
        tbl[11] = v(1, 0, 0, 0, 0, 2'b01, 9, 1);
        tbl[12] = v(1, 0, 0, 0, 0, 2'b00, 3, 0);
        tbl[13] = v(1, 0, 0, 0, 0, 2'b00, 3, 0);
        tbl[14] = v(1, 0, 0, 0, 0, 2'b00, 3, 0);
        tbl[15] = v(1, 0, 0, 0, 0, 2'b00, 3, 1);
        tbl[16] = v(1, 0, 0, 0, 0, 2'b10, 7, 0);
        tbl[17] = v(1, 0, 0, 0, 0, 2'b10, 7, 0);
        tbl[18] = v(1, 0, 0, 0, 0, 2'b10, 7, 0);
        tbl[19] = v(1, 0, 0, 0, 0, 2'b10, 7, 1);

        RSTN = 1'b0; EN = 1'b0; LOAD = 1'b0; D0 = 0; D1 = 0; D2 = 0;
        m_reset();
        repeat (2) @(posedge CLK);
        #1;
        drive("reset", 1'b0, 1'b1, 1'b1, 4'd5, 4'd6, 4'd7, 1'b1, '{2'b00, 4'd0, 1'b0});
        drive("reset", 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1, '{2'b00, 4'd0, 1'b0});

        for (int i = 0; i < 20; i++)
            drive($sformatf("table[%0d]", i), 1'b1, tbl[i].en, tbl[i].load, tbl[i].d0,
                  tbl[i].d1, tbl[i].d2, 1'b1, '{tbl[i].sel, tbl[i].dig, tbl[i].tick});

        // LOAD coinciding with TICK goes straight to the active buffer.
        guard = 0;
        while (m_cnt != DIV - 1 && guard < 20) begin run("seek", 1, 1, 0, 0, 0, 0); guard++; end
        run("load_on_tick", 1, 1, 1, 4'd1, 4'd2, 4'd5);
        run("after_tick_load", 14, 1, 0, 0, 0, 0);

        // EN low for 10 cycles mid-slot2 freezes everything.
        guard = 0;
        while (!(m_slot == 2 && m_cnt == 1) && guard < 20) begin run("seek", 1, 1, 0, 0, 0, 0); guard++; end
        run("en_low", 10, 0, 0, 0, 0, 0);
        run("en_resume", 8, 1, 0, 0, 0, 0);

        // LOAD while disabled, then repeated loads; last one wins.
        run("load_en0", 1, 0, 1, 4'd4, 4'd4, 4'd4);
        run("en0_hold", 3, 0, 0, 0, 0, 0);
        run("reload_a", 1, 1, 1, 4'd11, 4'd12, 4'd13);
        run("reload_b", 1, 1, 1, 4'd15, 4'd10, 4'd14);
        run("hex_pass", 14, 1, 0, 0, 0, 0);

        // Reset while a load is pending discards it.
        run("pend_set", 1, 1, 1, 4'd8, 4'd8, 4'd8);
        drive("reset_pend", 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, '0);
        drive("reset_pend", 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1, '{2'b00, 4'd0, 1'b0});
        run("post_reset", 14, 1, 0, 0, 0, 0);

        // Leading-zero blanking patterns (plain digits without the macro).
        run("blank_load", 1, 1, 1, 4'd4, 4'd0, 4'd0);
        run("blank_4_0_0", 14, 1, 0, 0, 0, 0);
        run("blank_load", 1, 1, 1, 4'd4, 4'd5, 4'd0);
        run("blank_4_5_0", 14, 1, 0, 0, 0, 0);

        for (int i = 0; i < 300; i++)
            drive("random", ($urandom % 60) != 0, ($urandom % 8) != 0, ($urandom % 6) == 0,
                  4'($urandom), 4'($urandom), 4'($urandom), 1'b0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/display_scanner.md
Name: display_scanner

Overview:
- Time-multiplexed scan controller for the 3-digit 7-segment display.
- Sits directly upstream of displayselector.
  - Its SEL0/SEL1 outputs drive that block's SEL0/SEL1 inputs.
  - Its DIGIT output feeds the BCD-to-segment decoder.
- Holds a double-buffered copy of three BCD digits and cycles through them at a prescaled refresh rate.
- New digit values are only applied on slot boundaries, so a digit never tears mid-slot.

Parameters:
- DIV, 4, refresh prescaler terminal count: clock cycles per digit slot (>=1).
- CNT_W, 16, prescaler counter width; DIV must be <= 2**CNT_W.

Ports:
- CLK  input  1  system clock, all logic on rising edge
- RSTN  input  1  synchronous active-low reset
- EN  input  1  scan enable; low freezes prescaler, slot and outputs
- LOAD  input  1  one-cycle strobe: capture D0..D2 into the shadow buffer
- D0  input  4  BCD units digit
- D1  input  4  BCD tens digit
- D2  input  4  BCD hundreds digit
- SEL0  output  1  select bit 0 to displayselector
- SEL1  output  1  select bit 1 to displayselector
- DIGIT  output  4  BCD value of the currently selected digit
- TICK  output  1  one-cycle pulse, high on the cycle the slot advances

Behaviour:
- Reset (RSTN=0 at rising CLK) wins over all other inputs:
  - prescaler=0, slot=0, shadow=0, active=0, pending=0;
  - SEL1,SEL0=00, DIGIT=0, TICK=0.
- Clock and reset: one clock domain; reset is synchronous and active-low; clock port CLK, reset port RSTN.
- Prescaler:
  - When EN=1, counts 0..DIV-1 and wraps to 0.
  - TICK is combinational: EN=1 && prescaler==DIV-1.
  - DIV=1 gives TICK on every enabled cycle.
- Slot sequence, advancing on TICK:
  - slot0 -> slot1 -> slot2 -> slot0, never any other order.
  - Select encoding (SEL1,SEL0): slot0 = 00 (digit 0 on), slot1 = 10 (digit 1 on), slot2 = 01 (digit 2 on).
  - Code 11 (all digits off) is never produced except by the optional feature.
- Outputs are registered:
  - SEL0/SEL1/DIGIT show the new slot one cycle after TICK.
  - DIGIT is the active-buffer value for the shown slot: D0 for slot0, D1 for slot1, D2 for slot2.
- Double buffering:
  - LOAD=1 writes D0..D2 into shadow and sets pending.
  - On TICK with pending=1: active<=shadow, pending<=0.
  - LOAD and TICK in the same cycle: the live D0..D2 go directly into active; pending stays 0.
  - Repeated LOADs before a TICK: the last one wins.
  - LOAD is honoured even when EN=0; its transfer waits for the next TICK.
- EN=0: prescaler, slot, SEL, DIGIT and active all hold; TICK=0.
- Values 10..15 pass through to DIGIT unchanged; no clamping.
- Reset mid-slot or mid-pending: everything returns to reset values and the pending load is lost.

Optional Feature:
- Macro: DISPLAY_BLANK_EN (leading-zero blanking).
- With the macro defined:
  - In slot2, if active D2==0, SEL1,SEL0=11.
  - In slot1, if active D2==0 and active D1==0, SEL1,SEL0=11.
  - Slot0 is never blanked.
  - DIGIT still carries the value, and slot timing is unchanged.
- Without the macro: never 11; all three digits always shown.

Decomposition:
- Package display_pkg holds:
  - constants SLOT0_SEL=2'b00, SLOT1_SEL=2'b10, SLOT2_SEL=2'b01, SEL_OFF=2'b11;
  - BCD_W=4;
  - a 2-bit slot typedef.
- One natural sub-module: display_prescaler (CLK, RSTN, EN -> TICK, parameters DIV/CNT_W).
- Slot FSM and buffers stay in display_scanner.

Test Plan:
- Reset, then EN=1, DIV=4:
  - first TICK at cycle 4 after release;
  - SEL1,SEL0 goes 00->10->01->00 every 4 cycles;
  - TICK is exactly one cycle wide.
- LOAD with D0=3,D1=7,D2=9 mid-slot:
  - DIGIT keeps its old value until the next TICK;
  - afterwards DIGIT reads 3/7/9 on slots 0/1/2.
- LOAD coinciding with TICK, D=1,2,5: applied on that TICK; pending not left set.
- EN=0 for 10 cycles mid-slot2: SEL=01 and DIGIT held; after EN=1 the remaining slot length is preserved.
- RSTN=0 while pending=1, then release: outputs 00/0; the old shadow is never displayed.
- DISPLAY_BLANK_EN, D2=0,D1=0,D0=4: slots 1 and 2 show SEL=11, slot0 shows 00/DIGIT=4; with D1=5, slot1 shows 10.
